// File: rtl/if_prefetch_pkg.sv
// Shared constants and fetch-FSM encoding for the instruction prefetch stage.
package if_prefetch_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic TRUE_V        = 1'b1;
  localparam logic FALSE_V       = 1'b0;
  localparam int   INST_ADDR_BUS = 32;
  localparam int   INST_BUS      = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_WAIT    = 2'b10,
    ST_DISCARD = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Circular prefetch queue: head visible combinationally, flush clears all entries.
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // A push into a full queue is accepted only when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && rst != RST_ENABLE) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a credit-limited prefetch queue and redirect flush.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_inst,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready,
  output logic              if_stall
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INST_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              unused_full;
  logic              outstanding;
  logic              credit;

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (fifo_push),
    .din   ({req_pc_q, mem_inst}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (unused_full),
    .empty (fifo_empty)
  );

  // Occupied slots plus the single in-flight request must stay below DEPTH.
  assign outstanding = (state_q != ST_IDLE);
  assign credit      = ({1'b0, fifo_count} + {{CW{1'b0}}, outstanding}) < (CW+1)'(DEPTH);

  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = mem_addr_q;
  assign id_valid = !fifo_empty;
  assign if_stall = fifo_empty;
  assign id_inst  = id_valid ? fifo_head[INST_W-1:0] : '0;
  assign id_pc    = id_valid ? fifo_head[EW-1:INST_W] : '0;
  assign fifo_pop = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    mem_addr_d = mem_addr_q;
    fifo_push  = FALSE_V;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // Any response already owed by memcontrol belongs to the old path.
      case (state_q)
        ST_REQ:              state_d = mem_ack ? ST_DISCARD : ST_IDLE;
        ST_WAIT, ST_DISCARD: state_d = mem_valid ? ST_IDLE : ST_DISCARD;
        default:             state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (credit) begin
            state_d    = ST_REQ;
            mem_addr_d = fetch_pc_q;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_d    = ST_WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          end
        end
        ST_WAIT: begin
          if (mem_valid) begin
            fifo_push = TRUE_V;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          if (mem_valid) state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the instruction-fetch stage. Owns the fetch PC and issues sequential fetch requests to memcontrol.
- Buffers returned instructions in a DEPTH-entry prefetch queue, so the handshake with memcontrol is decoupled from IF/ID back-pressure.
- Handles branch/jump redirects: flushes the queue and discards any in-flight stale response.
- Sits between pc logic/EX redirect and memcontrol on one side, and the IF/ID register on the other.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC loaded at reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch target.
- mem_req  out  1  fetch request to memcontrol.
- mem_addr  out  ADDR_W  request address.
- mem_ack  in  1  memcontrol accepted the request this cycle.
- mem_valid  in  1  instruction data returned this cycle.
- mem_inst  in  INST_W  returned instruction.
- id_valid  out  1  head of queue is valid.
- id_inst  out  INST_W  head instruction.
- id_pc  out  ADDR_W  PC of head instruction.
- id_ready  in  1  IF/ID consumes head this cycle (low = stall).
- if_stall  out  1  queue empty; asks the pipeline to bubble.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; FSM=IDLE; queue empty.
  - mem_req=0, mem_addr=0, id_valid=0, id_inst=0, id_pc=0, if_stall=1.
  - Reset overrides redirect and any in-flight transaction; a mem_valid arriving after reset is ignored unless FSM is WAIT.
- Credit rule: a request may start only if (count + outstanding) < DEPTH. At most one outstanding request.
- FSM states:
  - IDLE: if credit available and no redirect -> REQ, with mem_addr=fetch_pc.
  - REQ: mem_req=1 and mem_addr held stable until mem_ack. On mem_ack -> WAIT, req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^ADDR_W, wraps silently).
  - WAIT: on mem_valid, push {req_pc, mem_inst} -> IDLE.
  - DISCARD: on mem_valid, drop the data -> IDLE.
- Redirect (highest priority after reset), effective the same edge:
  - Queue flushed; fetch_pc<=redirect_pc.
  - From WAIT -> DISCARD; a mem_valid in that same cycle is also dropped and FSM -> IDLE.
  - From REQ: if mem_ack in the same cycle -> DISCARD, else -> IDLE (request withdrawn; mem_req=0 next cycle).
  - From DISCARD: stays DISCARD, with the new target recorded.
  - A pop in the redirect cycle has no effect beyond the flush.
- Queue:
  - Circular buffer, DEPTH entries; head shown combinationally on id_*.
  - id_valid = count != 0; if_stall = !id_valid.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle are legal, even when full; count unchanged.
  - Credit rule guarantees no push when full; pop on empty is ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Latency:
  - Request issued the cycle after IDLE with credit.
  - Instruction visible on id_* the cycle after the mem_valid edge.
  - Best-case throughput is one instruction per (ack + data) round trip.
- mem_addr holds its last value when mem_req=0.

Decomposition:
- Shared defines: RstEnable/True/False, InstAddrBus/InstBus widths, FSM state encodings (IDLE, REQ, WAIT, DISCARD, 2 bits).
- One sub-module: if_fifo, parametrised by WIDTH and DEPTH. Ports: clk, rst, flush, push, din, pop, dout, count, full, empty.

Test Plan:
- Reset, then memcontrol acks each request in 1 cycle and returns data 2 cycles later (0x00000013, 0x00100093, ...), id_ready=1 -> mem_addr sequence 0x0, 0x4, 0x8; id_pc/id_inst appear in order; no duplicates.
- id_ready=0, DEPTH=4 -> exactly 4 requests issued then mem_req stays 0; release id_ready -> 4 pops in consecutive cycles, then fetching resumes at 0x10.
- Redirect to 0x80 while in WAIT for 0x8 -> stale data for 0x8 dropped; queue empty; next mem_addr=0x80; first id_pc=0x80.
- Redirect to 0x200 while in REQ with no ack -> mem_req drops next cycle, then re-asserts with mem_addr=0x200.
- Redirect and mem_ack in the same cycle -> DISCARD; the following mem_valid is dropped; fetch resumes at the target.
- Set fetch_pc=0xFFFFFFFC via redirect -> fetches 0xFFFFFFFC then 0x00000000; rst asserted during WAIT -> all outputs at reset values, fetch restarts at RESET_PC.
